// File: rtl/link_bus_sched.sv
// Arbiter and controller for the 8-bit parallel/serial loopback link and its shared tristate databus.
// Optional build macro LINK_BITCHK_EN adds a frame-length check reported on a sticky len_err output.

module link_bus_sched #(
    parameter int TIMEOUT    = 32,
    parameter int RD_HOLD    = 2,
    parameter int FRAME_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_ad,
    input  logic       req_rd,
    input  logic       err_clr,
    input  logic       Dbit_ena,
    output logic       nGet_AD_data,
    output logic       use_p_in_bus,
    output logic       gnt_ad,
    output logic       gnt_rd,
    output logic       rd_valid,
    output logic       busy,
    output logic       have_data,
    output logic       timeout_err,
`ifdef LINK_BITCHK_EN
    output logic       len_err,
`endif
    output logic [7:0] frame_cnt
);

    // One counter width serves both the stall timer and the optional bit counter.
    localparam int CNT_MAX = (TIMEOUT > FRAME_BITS) ? TIMEOUT : FRAME_BITS;
    localparam int CW      = $clog2(CNT_MAX + 2);
    localparam int HW      = (RD_HOLD > 1) ? $clog2(RD_HOLD) : 1;
    localparam logic [CW-1:0] TIMER_LAST = CW'(TIMEOUT - 1);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(RD_HOLD - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_START,
        SHIFT,
        READ,
        ERR
    } state_t;

    state_t        state;
    logic          last_ad;
    logic [CW-1:0] timer;
    logic [HW-1:0] hold_cnt;
`ifdef LINK_BITCHK_EN
    localparam logic [CW-1:0] BITS_EXP = CW'(FRAME_BITS);
    logic [CW-1:0] bit_cnt;
`endif

    logic rd_eligible;
    logic pick_ad;
    logic pick_rd;

    // A readback only competes once a completed frame is waiting; ties go opposite the last winner.
    assign rd_eligible = req_rd & have_data;
    assign pick_ad     = req_ad & (~rd_eligible | ~last_ad);
    assign pick_rd     = rd_eligible & (~req_ad | last_ad);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_ad      <= 1'b0;
            timer        <= '0;
            hold_cnt     <= '0;
            nGet_AD_data <= 1'b1;
            use_p_in_bus <= 1'b1;
            gnt_ad       <= 1'b0;
            gnt_rd       <= 1'b0;
            rd_valid     <= 1'b0;
            busy         <= 1'b0;
            have_data    <= 1'b0;
            timeout_err  <= 1'b0;
            frame_cnt    <= 8'd0;
`ifdef LINK_BITCHK_EN
            bit_cnt      <= '0;
            len_err      <= 1'b0;
`endif
        end else begin
            gnt_ad       <= 1'b0;
            gnt_rd       <= 1'b0;
            rd_valid     <= 1'b0;
            nGet_AD_data <= 1'b1;
`ifdef LINK_BITCHK_EN
            if (err_clr) begin
                len_err <= 1'b0;
            end
`endif
            case (state)
                IDLE: begin
                    if (pick_ad) begin
                        gnt_ad  <= 1'b1;
                        last_ad <= 1'b1;
                        busy    <= 1'b1;
                        state   <= LOAD;
                    end else if (pick_rd) begin
                        gnt_rd       <= 1'b1;
                        last_ad      <= 1'b0;
                        busy         <= 1'b1;
                        use_p_in_bus <= 1'b0;
                        hold_cnt     <= '0;
                        rd_valid     <= (RD_HOLD == 1);
                        state        <= READ;
                    end
                end
                LOAD: begin
                    nGet_AD_data <= 1'b0;
                    timer        <= '0;
                    state        <= WAIT_START;
                end
                WAIT_START: begin
                    if (timer == TIMER_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= ERR;
                    end else if (Dbit_ena) begin
`ifdef LINK_BITCHK_EN
                        bit_cnt <= CW'(1);
`endif
                        state   <= SHIFT;
                    end else begin
                        timer <= timer + CW'(1);
                    end
                end
                SHIFT: begin
                    if (timer == TIMER_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= ERR;
                    end else if (Dbit_ena) begin
                        timer <= timer + CW'(1);
`ifdef LINK_BITCHK_EN
                        bit_cnt <= bit_cnt + CW'(1);
`endif
                    end else begin
                        frame_cnt <= frame_cnt + 8'd1;
                        busy      <= 1'b0;
                        state     <= IDLE;
`ifdef LINK_BITCHK_EN
                        // A short or long frame still counts but is never offered for readback.
                        if (bit_cnt != BITS_EXP) begin
                            len_err <= 1'b1;
                        end else begin
                            have_data <= 1'b1;
                        end
`else
                        have_data <= 1'b1;
`endif
                    end
                end
                READ: begin
                    if (hold_cnt == HOLD_LAST) begin
                        use_p_in_bus <= 1'b1;
                        have_data    <= 1'b0;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                        rd_valid <= ((hold_cnt + HW'(1)) == HOLD_LAST);
                    end
                end
                ERR: begin
                    use_p_in_bus <= 1'b1;
                    if (err_clr) begin
                        timeout_err <= 1'b0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    use_p_in_bus <= 1'b1;
                    busy         <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule
